// File: rtl/store_streamer_if.sv
// Bus bundle for store_streamer: controller request/status, buffer read
// port and transmit-FIFO write port. The master side is the streamer; the
// slave side is the environment (controller, unified buffer, FIFO).
interface store_streamer_if #(
    parameter int BUFFER_WORD_SIZE = 16,
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int ADDRESS_SIZE     = 10,
    parameter int COUNT_WIDTH      = 11
);
    logic                        start;
    logic [ADDRESS_SIZE-1:0]     base_addr;
    logic [COUNT_WIDTH-1:0]      word_count;
    logic                        busy;
    logic                        done;
    logic                        buf_re;
    logic [ADDRESS_SIZE-1:0]     buf_addr;
    logic [BUFFER_WORD_SIZE-1:0] buf_rdata;
    logic                        fifo_full;
    logic                        fifo_we;
    logic [FIFO_DATA_WIDTH-1:0]  fifo_wdata;

    modport master (
        input  start, base_addr, word_count, buf_rdata, fifo_full,
        output busy, done, buf_re, buf_addr, fifo_we, fifo_wdata
    );

    modport slave (
        output start, base_addr, word_count, buf_rdata, fifo_full,
        input  busy, done, buf_re, buf_addr, fifo_we, fifo_wdata
    );
endinterface

// File: rtl/store_streamer.sv
// Streams a contiguous range of unified-buffer words to the transmit FIFO,
// low byte first. One start pulse launches the transfer; a one-cycle done
// pulse marks completion. Each word costs READ, WAIT, SEND_LO, SEND_HI,
// with every fifo_full cycle in a SEND state stretching the word by one.
// BUFFER_WORD_SIZE must equal 2*FIFO_DATA_WIDTH, and the parameters must
// match those of the connected interface instance.
module store_streamer #(
    parameter int BUFFER_WORD_SIZE = 16,
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int ADDRESS_SIZE     = 10,
    parameter int COUNT_WIDTH      = 11
) (
    input  logic                clk,
    input  logic                rst,
    store_streamer_if.master    bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WAIT    = 3'd2,
        SEND_LO = 3'd3,
        SEND_HI = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                      state_reg;
    logic [ADDRESS_SIZE-1:0]     addr_reg;
    logic [COUNT_WIDTH-1:0]      rem_reg;
    logic [BUFFER_WORD_SIZE-1:0] word_reg;

    // Output registers, loaded together with the state they belong to so
    // every output except fifo_we is a pure flop.
    logic                        busy_reg;
    logic                        done_reg;
    logic                        buf_re_reg;
    logic [ADDRESS_SIZE-1:0]     buf_addr_reg;
    logic [FIFO_DATA_WIDTH-1:0]  wdata_reg;
    logic                        send_reg;

    // Transfer sequencer: state, address/count bookkeeping and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            rem_reg      <= '0;
            word_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            buf_re_reg   <= 1'b0;
            buf_addr_reg <= '0;
            wdata_reg    <= '0;
            send_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        addr_reg     <= bus.base_addr;
                        rem_reg      <= bus.word_count;
                        busy_reg     <= 1'b1;
                        buf_addr_reg <= bus.base_addr;
                        if (bus.word_count == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg  <= READ;
                            buf_re_reg <= 1'b1;
                        end
                    end
                end
                READ: begin
                    buf_re_reg <= 1'b0;
                    state_reg  <= WAIT;
                end
                WAIT: begin
                    // Buffer read latency is one cycle: data lands here.
                    word_reg  <= bus.buf_rdata;
                    wdata_reg <= bus.buf_rdata[FIFO_DATA_WIDTH-1:0];
                    send_reg  <= 1'b1;
                    state_reg <= SEND_LO;
                end
                SEND_LO: begin
                    if (!bus.fifo_full) begin
                        wdata_reg <= word_reg[BUFFER_WORD_SIZE-1:FIFO_DATA_WIDTH];
                        state_reg <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (!bus.fifo_full) begin
                        send_reg  <= 1'b0;
                        wdata_reg <= '0;
                        if (rem_reg == COUNT_WIDTH'(1)) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            // Address wraps naturally at 2^ADDRESS_SIZE.
                            addr_reg     <= addr_reg + 1'b1;
                            buf_addr_reg <= addr_reg + 1'b1;
                            rem_reg      <= rem_reg - 1'b1;
                            buf_re_reg   <= 1'b1;
                            state_reg    <= READ;
                        end
                    end
                end
                DONE: begin
                    done_reg     <= 1'b0;
                    busy_reg     <= 1'b0;
                    buf_addr_reg <= '0;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg    <= IDLE;
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b0;
                    buf_re_reg   <= 1'b0;
                    buf_addr_reg <= '0;
                    wdata_reg    <= '0;
                    send_reg     <= 1'b0;
                end
            endcase
        end
    end

    // Write strobe must react to fifo_full in the same cycle, so it is the
    // one output gated combinationally.
    assign bus.fifo_we    = send_reg & ~bus.fifo_full;
    assign bus.fifo_wdata = wdata_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.buf_re     = buf_re_reg;
    assign bus.buf_addr   = buf_addr_reg;
endmodule

// File: tb/tb_store_streamer.sv
// Scoreboard bench for store_streamer: stimulus pushes expected buffer
// reads, FIFO bytes and done pulses (with their cycle numbers); a negedge
// monitor pops and compares each one as the DUT presents it.
module tb_store_streamer;
    localparam int EV_RD = 1;
    localparam int EV_WR = 2;
    localparam int EV_DN = 3;

    typedef struct {
        int kind;
        int cyc;
        int data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   full_lo = -1;
    int   full_hi = -1;
    ev_t  exp_q[$];
    logic [15:0] mem [0:1023];

    store_streamer_if bus ();

    store_streamer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle number: cycle j is the period following the j-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Unified buffer model with one-cycle registered read.
    always @(posedge clk) begin
        if (bus.buf_re) bus.buf_rdata <= mem[bus.buf_addr];
    end

    // FIFO back-pressure driver: full during the window [full_lo, full_hi].
    always begin
        @(posedge clk);
        #1;
        bus.fifo_full = (cyc >= full_lo) && (cyc <= full_hi);
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int data);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_start(input logic [9:0] a, input logic [10:0] n, output int k);
        tick();
        bus.start      = 1'b1;
        bus.base_addr  = a;
        bus.word_count = n;
        k = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_busy"},   int'(bus.busy),       0);
        check({tag, "_done"},   int'(bus.done),       0);
        check({tag, "_buf_re"}, int'(bus.buf_re),     0);
        check({tag, "_addr"},   int'(bus.buf_addr),   0);
        check({tag, "_we"},     int'(bus.fifo_we),    0);
        check({tag, "_wdata"},  int'(bus.fifo_wdata), 0);
    endtask

    // Monitor: every read, byte write or done pulse must match the queue head.
    always @(negedge clk) begin
        int  kind;
        int  data;
        ev_t e;
        if (bus.fifo_full) check("we_while_full", int'(bus.fifo_we), 0);
        if (bus.done || bus.buf_re || bus.fifo_we) begin
            kind = bus.done ? EV_DN : (bus.buf_re ? EV_RD : EV_WR);
            data = bus.buf_re ? int'(bus.buf_addr) : (bus.fifo_we ? int'(bus.fifo_wdata) : 0);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got kind %0d data 0x%0h at cycle %0d, expected none",
                         kind, data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != kind || e.cyc != cyc || e.data != data) begin
                    n_bad++;
                    $display("FAIL event: got kind %0d data 0x%0h cycle %0d, expected kind %0d data 0x%0h cycle %0d",
                             kind, data, cyc, e.kind, e.data, e.cyc);
                end else begin
                    $display("ok   event: kind %0d data 0x%0h cycle %0d", kind, data, cyc);
                end
            end
        end
    end

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[5]    = 16'hA5C3;
        mem[10]   = 16'h1100;
        mem[11]   = 16'h3322;
        mem[12]   = 16'h5544;
        mem[1023] = 16'hBEEF;
        mem[0]    = 16'h1234;
        mem[20]   = 16'h6655;
        mem[21]   = 16'h8877;
        mem[22]   = 16'hAA99;
        bus.buf_rdata  = 16'h0000;
        bus.fifo_full  = 1'b0;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;

        // Reset state.
        repeat (3) tick();
        rst = 1'b0;
        check_idle_outputs("reset");

        // Single word: busy spans k+1..k+5.
        do_start(10'd5, 11'd1, k);
        push(EV_RD, k + 1, 5);
        push(EV_WR, k + 3, 'hC3);
        push(EV_WR, k + 4, 'hA5);
        push(EV_DN, k + 5, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("single_busy", int'(bus.busy), (cyc >= k + 1 && cyc <= k + 5) ? 1 : 0);
        end
        wait_until(k + 7);

        // Burst of three, with an ignored start pulse while busy.
        do_start(10'd10, 11'd3, k);
        push(EV_RD, k + 1, 10);
        push(EV_WR, k + 3, 'h00);
        push(EV_WR, k + 4, 'h11);
        push(EV_RD, k + 5, 11);
        push(EV_WR, k + 7, 'h22);
        push(EV_WR, k + 8, 'h33);
        push(EV_RD, k + 9, 12);
        push(EV_WR, k + 11, 'h44);
        push(EV_WR, k + 12, 'h55);
        push(EV_DN, k + 13, 0);
        wait_until(k + 3);
        bus.start      = 1'b1;
        bus.base_addr  = 10'd5;
        bus.word_count = 11'd1;
        tick();
        bus.start = 1'b0;
        wait_until(k + 15);

        // Back-pressure: full for three cycles starting in SEND_HI.
        do_start(10'd5, 11'd1, k);
        full_lo = k + 4;
        full_hi = k + 6;
        push(EV_RD, k + 1, 5);
        push(EV_WR, k + 3, 'hC3);
        push(EV_WR, k + 7, 'hA5);
        push(EV_DN, k + 8, 0);
        wait_until(k + 10);
        full_lo = -1;
        full_hi = -1;

        // Zero count: done only.
        do_start(10'd7, 11'd0, k);
        push(EV_DN, k + 1, 0);
        wait_until(k + 4);

        // Address wrap 1023 -> 0.
        do_start(10'd1023, 11'd2, k);
        push(EV_RD, k + 1, 1023);
        push(EV_WR, k + 3, 'hEF);
        push(EV_WR, k + 4, 'hBE);
        push(EV_RD, k + 5, 0);
        push(EV_WR, k + 7, 'h34);
        push(EV_WR, k + 8, 'h12);
        push(EV_DN, k + 9, 0);
        wait_until(k + 11);

        // Reset during SEND_HI of word 2 of 3: that byte still strobes in
        // the reset cycle (synchronous reset), then nothing, and no done.
        do_start(10'd20, 11'd3, k);
        push(EV_RD, k + 1, 20);
        push(EV_WR, k + 3, 'h55);
        push(EV_WR, k + 4, 'h66);
        push(EV_RD, k + 5, 21);
        push(EV_WR, k + 7, 'h77);
        push(EV_WR, k + 8, 'h88);
        wait_until(k + 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("midreset");
        wait_until(k + 16);

        // Fresh start after reset behaves as from reset.
        do_start(10'd5, 11'd1, k);
        push(EV_RD, k + 1, 5);
        push(EV_WR, k + 3, 'hC3);
        push(EV_WR, k + 4, 'hA5);
        push(EV_DN, k + 5, 0);
        wait_until(k + 8);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
